// File: rtl/stack_tos_unit.sv
// Flop-based hardware data stack with registered TOS/NOS views and an overflow/underflow/illegal fault FSM.
// Optional feature: define STACK_SWAP_EN to build op 110 (SWAP); without it op 110 faults as illegal.
module stack_tos_unit #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_fault,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             fault,
    output logic [1:0]       fault_code
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = CW'(1'b0);
    localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
    localparam logic [CW-1:0] TWO_C   = CW'(2'd2);
    localparam logic [CW-1:0] THREE_C = CW'(2'd3);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_BINOP   = 3'b011;
    localparam logic [2:0] OP_REPLACE = 3'b100;
    localparam logic [2:0] OP_DUP     = 3'b101;
`ifdef STACK_SWAP_EN
    localparam logic [2:0] OP_SWAP    = 3'b110;
`endif

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OVF  = 2'd1;
    localparam logic [1:0] FC_UNF  = 2'd2;
    localparam logic [1:0] FC_ILL  = 2'd3;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [0:0]       state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] tos_r;
    logic [WIDTH-1:0] nos_r;
    logic             empty_r;
    logic             full_r;
    logic             fault_r;
    logic             op_ready_r;
    logic [1:0]       code_r;

    logic             accept_s;
    logic             commit_s;
    logic             err_s;
    logic [1:0]       code_s;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] tos_next_s;
    logic [WIDTH-1:0] nos_next_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_idx_s;
    logic [WIDTH-1:0] wr_data_s;
`ifdef STACK_SWAP_EN
    logic             wr2_en_s;
    logic [AW-1:0]    wr2_idx_s;
    logic [WIDTH-1:0] wr2_data_s;
`endif
    logic             has1_s;
    logic             has2_s;
    logic             has3_s;
    logic             at_full_s;
    logic [AW-1:0]    idx_push_s;
    logic [AW-1:0]    idx_top_s;
    logic [AW-1:0]    idx_nos_s;
    logic [AW-1:0]    idx_third_s;
    logic [WIDTH-1:0] third_s;

    // Occupancy flags and slot indices; the third entry becomes NOS after a pop or binop
    always_comb begin
        has1_s      = (count_r >= ONE_C);
        has2_s      = (count_r >= TWO_C);
        has3_s      = (count_r >= THREE_C);
        at_full_s   = (count_r == DEPTH_C);
        idx_push_s  = AW'(count_r);
        idx_top_s   = AW'(count_r - ONE_C);
        idx_nos_s   = AW'(count_r - TWO_C);
        idx_third_s = AW'(count_r - THREE_C);
        if (has3_s) begin
            third_s = mem_r[idx_third_s];
        end else begin
            third_s = {WIDTH{1'b0}};
        end
    end

    // Op decode: bounds checks, next TOS/NOS/count and storage writes (tos_r/nos_r mirror the top two slots)
    always_comb begin
        accept_s     = op_valid & op_ready_r;
        err_s        = 1'b0;
        code_s       = FC_NONE;
        count_next_s = count_r;
        tos_next_s   = tos_r;
        nos_next_s   = nos_r;
        wr_en_s      = 1'b0;
        wr_idx_s     = idx_push_s;
        wr_data_s    = din;
`ifdef STACK_SWAP_EN
        wr2_en_s     = 1'b0;
        wr2_idx_s    = idx_nos_s;
        wr2_data_s   = tos_r;
`endif
        case (op)
            OP_NOP: begin
                err_s = 1'b0;
            end
            OP_PUSH: begin
                if (at_full_s) begin
                    err_s  = 1'b1;
                    code_s = FC_OVF;
                end else begin
                    wr_en_s      = 1'b1;
                    wr_idx_s     = idx_push_s;
                    wr_data_s    = din;
                    count_next_s = count_r + ONE_C;
                    tos_next_s   = din;
                    nos_next_s   = tos_r;
                end
            end
            OP_POP: begin
                if (!has1_s) begin
                    err_s  = 1'b1;
                    code_s = FC_UNF;
                end else begin
                    count_next_s = count_r - ONE_C;
                    tos_next_s   = nos_r;
                    nos_next_s   = third_s;
                end
            end
            OP_BINOP: begin
                if (!has2_s) begin
                    err_s  = 1'b1;
                    code_s = FC_UNF;
                end else begin
                    wr_en_s      = 1'b1;
                    wr_idx_s     = idx_nos_s;
                    wr_data_s    = din;
                    count_next_s = count_r - ONE_C;
                    tos_next_s   = din;
                    nos_next_s   = third_s;
                end
            end
            OP_REPLACE: begin
                if (!has1_s) begin
                    err_s  = 1'b1;
                    code_s = FC_UNF;
                end else begin
                    wr_en_s    = 1'b1;
                    wr_idx_s   = idx_top_s;
                    wr_data_s  = din;
                    tos_next_s = din;
                end
            end
            OP_DUP: begin
                // empty is reported before full
                if (!has1_s) begin
                    err_s  = 1'b1;
                    code_s = FC_UNF;
                end else if (at_full_s) begin
                    err_s  = 1'b1;
                    code_s = FC_OVF;
                end else begin
                    wr_en_s      = 1'b1;
                    wr_idx_s     = idx_push_s;
                    wr_data_s    = tos_r;
                    count_next_s = count_r + ONE_C;
                    nos_next_s   = tos_r;
                end
            end
`ifdef STACK_SWAP_EN
            OP_SWAP: begin
                if (!has2_s) begin
                    err_s  = 1'b1;
                    code_s = FC_UNF;
                end else begin
                    wr_en_s    = 1'b1;
                    wr_idx_s   = idx_top_s;
                    wr_data_s  = nos_r;
                    wr2_en_s   = 1'b1;
                    wr2_idx_s  = idx_nos_s;
                    wr2_data_s = tos_r;
                    tos_next_s = nos_r;
                    nos_next_s = tos_r;
                end
            end
`endif
            default: begin
                err_s  = 1'b1;
                code_s = FC_ILL;
            end
        endcase
    end

    assign commit_s = accept_s & ~err_s;

    // Stack storage; popped slots keep stale data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (commit_s && wr_en_s) begin
                mem_r[wr_idx_s] <= wr_data_s;
            end
`ifdef STACK_SWAP_EN
            if (commit_s && wr2_en_s) begin
                mem_r[wr2_idx_s] <= wr2_data_s;
            end
`endif
        end
    end

    // RUN/FAULT control plus registered views of the stack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_RUN;
            count_r    <= ZERO_C;
            tos_r      <= {WIDTH{1'b0}};
            nos_r      <= {WIDTH{1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            fault_r    <= 1'b0;
            op_ready_r <= 1'b1;
            code_r     <= FC_NONE;
        end else if (state_r == ST_FAULT) begin
            if (clr_fault) begin
                state_r    <= ST_RUN;
                fault_r    <= 1'b0;
                op_ready_r <= 1'b1;
                code_r     <= FC_NONE;
            end
        end else if (accept_s) begin
            if (err_s) begin
                state_r    <= ST_FAULT;
                fault_r    <= 1'b1;
                op_ready_r <= 1'b0;
                code_r     <= code_s;
            end else begin
                count_r <= count_next_s;
                tos_r   <= tos_next_s;
                nos_r   <= nos_next_s;
                empty_r <= (count_next_s == ZERO_C);
                full_r  <= (count_next_s == DEPTH_C);
            end
        end
    end

    assign op_ready   = op_ready_r;
    assign tos        = tos_r;
    assign nos        = nos_r;
    assign count      = count_r;
    assign empty      = empty_r;
    assign full       = full_r;
    assign fault      = fault_r;
    assign fault_code = code_r;

endmodule

// File: tb/tb_stack_tos_unit.sv
// Directed bench for stack_tos_unit: queue-based stack model compared every cycle, plus literal spot checks.
module tb_stack_tos_unit;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic [2:0]       op;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] din;
    logic             clr_fault;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             fault;
    logic [1:0]       fault_code;

    stack_tos_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .op_ready(op_ready),
        .din(din), .clr_fault(clr_fault), .tos(tos), .nos(nos), .count(count),
        .empty(empty), .full(full), .fault(fault), .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic check_en = 1'b0;

    logic [WIDTH-1:0] stk[$];
    logic             m_fault = 1'b0;
    logic [1:0]       m_code  = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_fault(input logic [1:0] c);
        m_fault = 1'b1;
        m_code  = c;
    endtask

    task automatic model_apply(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic v, input logic c);
        int n;
        logic [WIDTH-1:0] t;
        n = stk.size();
        if (m_fault) begin
            if (c) begin
                m_fault = 1'b0;
                m_code  = 2'd0;
            end
        end else if (v) begin
            case (o)
                3'd0: ;
                3'd1: if (n >= DEPTH) set_fault(2'd1); else stk.push_back(d);
                3'd2: if (n < 1) set_fault(2'd2); else void'(stk.pop_back());
                3'd3: if (n < 2) set_fault(2'd2); else begin void'(stk.pop_back()); stk[n-2] = d; end
                3'd4: if (n < 1) set_fault(2'd2); else stk[n-1] = d;
                3'd5: if (n < 1) set_fault(2'd2); else if (n >= DEPTH) set_fault(2'd1); else stk.push_back(stk[n-1]);
`ifdef STACK_SWAP_EN
                3'd6: if (n < 2) set_fault(2'd2); else begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
`endif
                default: set_fault(2'd3);
            endcase
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        int n;
        logic [WIDTH-1:0] et;
        logic [WIDTH-1:0] en;
        if (check_en) begin
            n  = stk.size();
            et = (n >= 1) ? stk[n-1] : 16'h0000;
            en = (n >= 2) ? stk[n-2] : 16'h0000;
            chk("tos", 32'(tos), 32'(et));
            chk("nos", 32'(nos), 32'(en));
            chk("count", 32'(count), 32'(n));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("full", 32'(full), 32'(n == DEPTH));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fault_code", 32'(fault_code), 32'(m_code));
            chk("op_ready", 32'(op_ready), 32'(!m_fault));
        end
    end

    task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic v, input logic c);
        op = o; din = d; op_valid = v; clr_fault = c;
        @(posedge clk);
        model_apply(o, d, v, c);
        @(negedge clk);
        op_valid = 1'b0; clr_fault = 1'b0;
    endtask

    task automatic clear();
        step(3'd0, 16'h0000, 1'b0, 1'b1);
    endtask

    initial begin
        op = 3'd0; din = 16'h0000; op_valid = 1'b0; clr_fault = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_tos", 32'(tos), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_fault", 32'(fault), 32'd0);
        #9 reset = 1'b1;
        @(negedge clk);
        check_en = 1'b1;

        step(3'd1, 16'h1111, 1'b1, 1'b0);
        step(3'd1, 16'h2222, 1'b1, 1'b0);
        step(3'd1, 16'h3333, 1'b1, 1'b0);
        chk("push3_count", 32'(count), 32'd3);
        chk("push3_tos", 32'(tos), 32'h3333);
        chk("push3_nos", 32'(nos), 32'h2222);
        chk("push3_empty", 32'(empty), 32'd0);

        step(3'd3, 16'h5555, 1'b1, 1'b0);
        chk("binop_count", 32'(count), 32'd2);
        chk("binop_tos", 32'(tos), 32'h5555);
        chk("binop_nos", 32'(nos), 32'h1111);
        step(3'd2, 16'h0000, 1'b1, 1'b0);
        chk("pop_tos", 32'(tos), 32'h1111);
        chk("pop_nos", 32'(nos), 32'h0000);
        step(3'd2, 16'h0000, 1'b1, 1'b0);

        // underflow on empty for POP, REPLACE, DUP
        for (int k = 0; k < 3; k++) begin
            step((k == 0) ? 3'd2 : (k == 1) ? 3'd4 : 3'd5, 16'h7777, 1'b1, 1'b0);
            chk("empty_unf_code", 32'(fault_code), 32'd2);
            chk("empty_unf_count", 32'(count), 32'd0);
            clear();
        end

        step(3'd1, 16'h0123, 1'b1, 1'b0);
        step(3'd5, 16'h0000, 1'b1, 1'b0);
        chk("dup_nos", 32'(nos), 32'h0123);
        step(3'd4, 16'h4567, 1'b1, 1'b0);
        chk("replace_tos", 32'(tos), 32'h4567);
        step(3'd3, 16'h89ab, 1'b1, 1'b0);
        step(3'd3, 16'hcdef, 1'b1, 1'b0);
        chk("binop_unf_code", 32'(fault_code), 32'd2);
        step(3'd1, 16'h9999, 1'b1, 1'b0);
        step(3'd1, 16'h9999, 1'b1, 1'b1);
        chk("clr_ignores_op", 32'(count), 32'd1);
        step(3'd0, 16'h0000, 1'b0, 1'b1);
        step(3'd0, 16'h0000, 1'b1, 1'b0);
        step(3'd1, 16'hdead, 1'b0, 1'b0);
        step(3'd2, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < DEPTH; i++) step(3'd1, 16'(16'h1000 + i), 1'b1, 1'b0);
        step(3'd1, 16'hBEEF, 1'b1, 1'b0);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_fault", 32'(fault), 32'd1);
        chk("ovf_code", 32'(fault_code), 32'd1);
        chk("ovf_op_ready", 32'(op_ready), 32'd0);
        chk("ovf_tos", 32'(tos), 32'h100F);
        clear();
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_code", 32'(fault_code), 32'd0);
        chk("clr_count", 32'(count), 32'(DEPTH));
        step(3'd5, 16'h0000, 1'b1, 1'b0);
        chk("dup_full_code", 32'(fault_code), 32'd1);
        clear();
        step(3'd7, 16'h0000, 1'b1, 1'b0);
        chk("illegal_code", 32'(fault_code), 32'd3);
        clear();

        for (int i = 0; i < DEPTH; i++) step(3'd2, 16'h0000, 1'b1, 1'b0);
        step(3'd1, 16'hAAAA, 1'b1, 1'b0);
        step(3'd6, 16'h0000, 1'b1, 1'b0);
`ifdef STACK_SWAP_EN
        chk("swap1_code", 32'(fault_code), 32'd2);
`else
        chk("swap1_code", 32'(fault_code), 32'd3);
`endif
        clear();
        step(3'd1, 16'hBBBB, 1'b1, 1'b0);
        step(3'd6, 16'h0000, 1'b1, 1'b0);
`ifdef STACK_SWAP_EN
        chk("swap_tos", 32'(tos), 32'hAAAA);
        chk("swap_nos", 32'(nos), 32'hBBBB);
`else
        chk("swap_code", 32'(fault_code), 32'd3);
`endif
        clear();

        for (int i = 0; i < 3; i++) step(3'd1, 16'(16'h5000 + i), 1'b1, 1'b0);
        // reset pulse of half a cycle straddling the edge of an accepted PUSH
        op = 3'd1; din = 16'h6666; op_valid = 1'b1; clr_fault = 1'b0;
        check_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_tos", 32'(tos), 32'd0);
        chk("midrst_fault", 32'(fault), 32'd0);
        stk.delete();
        m_fault = 1'b0;
        m_code  = 2'd0;
        @(posedge clk);
        #1 reset = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        check_en = 1'b1;
        step(3'd1, 16'h7abc, 1'b1, 1'b0);
        chk("post_rst_tos", 32'(tos), 32'h7abc);
        chk("post_rst_count", 32'(count), 32'd1);
        step(3'd0, 16'h0000, 1'b0, 1'b0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
